// File: rtl/pwm_pkg.sv
// Shared constants, pin configuration struct and per-pin drive rule for the PWM output stage.
// Pure definitions: no latency, no flow control.
package pwm_pkg;

  localparam int PWM_CNT_W = 8;
  localparam int PWM_STEPS = 256;
  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam int N_PINS = 16;

  typedef struct packed {
    logic [N_PINS-1:0] en_out;
    logic [N_PINS-1:0] en_pwm;
  } pin_cfg_t;

  // Disabled pins are 0 regardless of PWM mode; enabled non-PWM pins are static 1.
  function automatic logic [N_PINS-1:0] pin_drive(pin_cfg_t cfg, logic level);
    return cfg.en_out & (~cfg.en_pwm | {N_PINS{level}});
  endfunction

endpackage

// File: rtl/pwm_output_stage_if.sv
// Control registers from the SPI register file and the registered pin drive.
// No latency or backpressure: plain register-level signals.
interface pwm_output_stage_if;
  import pwm_pkg::*;

  logic [7:0]        en_reg_out_7_0;
  logic [7:0]        en_reg_out_15_8;
  logic [7:0]        en_reg_pwm_7_0;
  logic [7:0]        en_reg_pwm_15_8;
  logic [7:0]        pwm_duty_cycle;
  logic [N_PINS-1:0] out_pins;
  logic              period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out_pins, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out_pins, period_start
  );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaled 8-bit PWM counter with period-boundary duty shadow; pwm_level is combinational from state.
// period_start is registered twice so it lines up with the output register stage; no backpressure.
module pwm_timebase import pwm_pkg::*; #(
  parameter int PRESCALE = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PWM_CNT_W-1:0] duty_in,
  output logic                 pwm_level,
  output logic                 period_start
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRESC_W-1:0]   PRESC_LAST = PRESC_W'(PRESCALE - 1);
  localparam logic [PWM_CNT_W-1:0] CNT_LAST   = PWM_CNT_W'(PWM_STEPS - 1);

  logic [PRESC_W-1:0]   presc_cnt;
  logic [PWM_CNT_W-1:0] pwm_cnt;
  logic [PWM_CNT_W-1:0] duty_shadow;
  logic                 tick;
  logic                 wrap;
  logic                 boundary_q;

  assign tick = (presc_cnt == PRESC_LAST);
  assign wrap = tick && (pwm_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt    <= '0;
      pwm_cnt      <= '0;
      duty_shadow  <= '0;
      boundary_q   <= 1'b0;
      period_start <= 1'b0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      // Duty only changes at the wrap so a period is never cut short or stretched.
      if (wrap) begin
        duty_shadow <= duty_in;
      end
      // boundary_q marks the live cycle at count 0; one more stage matches out_pins.
      boundary_q   <= wrap;
      period_start <= boundary_q;
    end
  end

  assign pwm_level = (duty_shadow == DUTY_FULL) || (pwm_cnt < duty_shadow);

endmodule

// File: rtl/pwm_output_stage.sv
// Per-pin off / static-on / PWM select driving 16 registered pins from the shared timebase.
// Latency 1 clk from enables or PWM level to pins; no backpressure.
module pwm_output_stage import pwm_pkg::*; #(
  parameter int PRESCALE = 13
) (
  input logic               clk,
  input logic               rst,
  pwm_output_stage_if.slave ctrl
);

  pin_cfg_t          cfg;
  logic              pwm_level;
  logic [N_PINS-1:0] out_q;

  assign cfg.en_out = {ctrl.en_reg_out_15_8, ctrl.en_reg_out_7_0};
  assign cfg.en_pwm = {ctrl.en_reg_pwm_15_8, ctrl.en_reg_pwm_7_0};

  pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .duty_in      (ctrl.pwm_duty_cycle),
    .pwm_level    (pwm_level),
    .period_start (ctrl.period_start)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= pin_drive(cfg, pwm_level);
    end
  end

  assign ctrl.out_pins = out_q;

endmodule

// File: tb/tb_pwm_output_stage.sv
// Three stage instances (PRESCALE 13, 2, 1) checked every cycle against a cycle-count model,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_output_stage;

  localparam int NDUT = 3;
  localparam int PRE [NDUT] = '{13, 2, 1};

  logic clk;
  logic rst;
  logic mon_en;
  int   checks;
  int   errors;

  logic [15:0] en_out_v [NDUT];
  logic [15:0] en_pwm_v [NDUT];
  logic [7:0]  duty_v   [NDUT];
  logic [15:0] dut_out  [NDUT];
  logic        dut_ps   [NDUT];
  logic [15:0] exp_out  [NDUT];
  logic        exp_ps   [NDUT];
  int          mdl_n    [NDUT];
  logic [7:0]  mdl_duty [NDUT];

  pwm_output_stage_if if0 ();
  pwm_output_stage_if if1 ();
  pwm_output_stage_if if2 ();

  pwm_output_stage #(.PRESCALE(13)) u_dut0 (.clk(clk), .rst(rst), .ctrl(if0));
  pwm_output_stage #(.PRESCALE(2))  u_dut1 (.clk(clk), .rst(rst), .ctrl(if1));
  pwm_output_stage #(.PRESCALE(1))  u_dut2 (.clk(clk), .rst(rst), .ctrl(if2));

  assign if0.en_reg_out_7_0  = en_out_v[0][7:0];
  assign if0.en_reg_out_15_8 = en_out_v[0][15:8];
  assign if0.en_reg_pwm_7_0  = en_pwm_v[0][7:0];
  assign if0.en_reg_pwm_15_8 = en_pwm_v[0][15:8];
  assign if0.pwm_duty_cycle  = duty_v[0];
  assign if1.en_reg_out_7_0  = en_out_v[1][7:0];
  assign if1.en_reg_out_15_8 = en_out_v[1][15:8];
  assign if1.en_reg_pwm_7_0  = en_pwm_v[1][7:0];
  assign if1.en_reg_pwm_15_8 = en_pwm_v[1][15:8];
  assign if1.pwm_duty_cycle  = duty_v[1];
  assign if2.en_reg_out_7_0  = en_out_v[2][7:0];
  assign if2.en_reg_out_15_8 = en_out_v[2][15:8];
  assign if2.en_reg_pwm_7_0  = en_pwm_v[2][7:0];
  assign if2.en_reg_pwm_15_8 = en_pwm_v[2][15:8];
  assign if2.pwm_duty_cycle  = duty_v[2];

  assign dut_out[0] = if0.out_pins;
  assign dut_out[1] = if1.out_pins;
  assign dut_out[2] = if2.out_pins;
  assign dut_ps[0]  = if0.period_start;
  assign dut_ps[1]  = if1.period_start;
  assign dut_ps[2]  = if2.period_start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level of the shared waveform in cycle n after reset release, from arithmetic on n.
  function automatic logic model_level(int n, int p, logic [7:0] duty);
    int step_in_period;
    step_in_period = (n / p) % 256;
    return (duty == 8'hFF) || (step_in_period < int'(duty));
  endfunction

  // Model: cycle n since release; duty for a period is the input seen in the last cycle of the previous one.
  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        mdl_n[d]    <= 0;
        mdl_duty[d] <= 8'h00;
        exp_out[d]  <= 16'h0000;
        exp_ps[d]   <= 1'b0;
      end else begin
        exp_out[d]  <= en_out_v[d] & (~en_pwm_v[d] | {16{model_level(mdl_n[d], PRE[d], mdl_duty[d])}});
        exp_ps[d]   <= (mdl_n[d] > 0) && (mdl_n[d] % (256 * PRE[d]) == 0);
        mdl_duty[d] <= ((mdl_n[d] + 1) % (256 * PRE[d]) == 0) ? duty_v[d] : mdl_duty[d];
        mdl_n[d]    <= mdl_n[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < NDUT; d++) begin
        checks++;
        if (dut_out[d] !== exp_out[d]) begin
          errors++;
          $display("FAIL model_out dut%0d @%0t: got 0x%04h expected 0x%04h", d, $time, dut_out[d], exp_out[d]);
        end
        checks++;
        if (dut_ps[d] !== exp_ps[d]) begin
          errors++;
          $display("FAIL model_ps dut%0d @%0t: got %b expected %b", d, $time, dut_ps[d], exp_ps[d]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ps(input int d, input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (dut_ps[d] === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_pin0(input int d, input int cycles, output int hi);
    hi = 0;
    for (int i = 0; i < cycles; i++) begin
      hi += int'(dut_out[d][0]);
      @(negedge clk);
    end
  endtask

  initial begin
    logic ok;
    int   hi;
    int   psc;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      en_out_v[d] = 16'h0000;
      en_pwm_v[d] = 16'h0000;
      duty_v[d]   = 8'h00;
    end
    rst = 1'b0;
    #2 rst = 1'b1;
    #1 mon_en = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", {16'h0, dut_out[0]}, 32'h0);
    check("reset_ps", {31'h0, dut_ps[0]}, 32'h0);

    // Release reset together with the first configuration of every instance.
    en_out_v[0] = 16'hFFFF; en_pwm_v[0] = 16'h0000; duty_v[0] = 8'h37;
    en_out_v[1] = 16'h0001; en_pwm_v[1] = 16'h0001; duty_v[1] = 8'h80;
    en_out_v[2] = 16'h0001; en_pwm_v[2] = 16'h0001; duty_v[2] = 8'h00;
    rst = 1'b0;
    @(negedge clk);
    check("static_1clk", {16'h0, dut_out[0]}, 32'hFFFF);

    // PRESCALE 2, duty 0x80: 256 high, 256 low, pulse every 512 aligned with the rise.
    wait_ps(1, 1200, ok);
    check("p2_ps_seen", {31'h0, ok}, 32'h1);
    check("p2_rise_aligned", {31'h0, dut_out[1][0]}, 32'h1);
    count_pin0(1, 512, hi);
    check("p2_high_cycles", hi, 256);
    check("p2_ps_period_512", {31'h0, dut_ps[1]}, 32'h1);

    // PRESCALE 1, duty 0x00 programmed since release: pin 0 never high.
    count_pin0(2, 300, hi);
    check("duty00_const0", hi, 0);

    duty_v[2] = 8'hFF;
    repeat (3) @(negedge clk);
    wait_ps(2, 300, ok);
    check("ff_ps_seen", {31'h0, ok}, 32'h1);
    count_pin0(2, 256, hi);
    check("dutyff_full_period", hi, 256);

    // Mid-period change 0x40 -> 0xC0 with the live counter at 0x20.
    duty_v[2] = 8'h40;
    repeat (3) @(negedge clk);
    wait_ps(2, 300, ok);
    check("mid_ps_seen", {31'h0, ok}, 32'h1);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      hi += int'(dut_out[2][0]);
      if (i == 31) duty_v[2] = 8'hC0;
      @(negedge clk);
    end
    check("mid_cur_period_64", hi, 64);
    check("mid_next_ps", {31'h0, dut_ps[2]}, 32'h1);
    count_pin0(2, 256, hi);
    check("mid_next_period_192", hi, 192);

    // Mixed enables on PRESCALE 13, then back to static and across a period boundary.
    en_out_v[0] = 16'hA5A5; en_pwm_v[0] = 16'h00FF; duty_v[0] = 8'h00;
    @(negedge clk);
    check("mixed_a500", {16'h0, dut_out[0]}, 32'hA500);
    en_out_v[0] = 16'hFFFF; en_pwm_v[0] = 16'h0000; duty_v[0] = 8'h37;
    repeat (3400) @(negedge clk);
    check("static_across_periods", {16'h0, dut_out[0]}, 32'hFFFF);

    // Asynchronous reset away from any clock edge.
    #2 rst = 1'b1;
    #1 check("rst_async_out", {16'h0, dut_out[0]}, 32'h0);
    check("rst_async_pin0_p2", {31'h0, dut_out[1][0]}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    psc = 0;
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      psc += int'(dut_ps[2]);
      hi  += int'(dut_out[2][0]);
    end
    check("post_rst_ps_quiet", psc, 0);
    check("post_rst_pwm_low", hi, 0);
    @(negedge clk);
    check("post_rst_ps_at_257", {31'h0, dut_ps[2]}, 32'h1);
    check("post_rst_pwm_rises", {31'h0, dut_out[2][0]}, 32'h1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
